pipelined_sub32: RTL and testbench

- Pipelined, handshaked 32-bit subtractor: computes diff = a - b - bin, with borrow-out and signed-overflow flags.
- Subtraction is split into borrow-rippled 8-bit slices, one slice per pipeline stage, so the worst-case path is one slice deep.
- Sits beside the combinational 32-bit CLA adder in the arithmetic datapath; serves ALU subtract/compare paths that need a registered, stallable result.

---
 rtl/arith_pkg.sv | 46 ++++
 rtl/sub_slice8.sv | 37 +++
 rtl/pipelined_sub32.sv | 147 ++++++++++++++
 tb/tb_pipelined_sub32.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the pipelined arithmetic datapath.
//   WIDTH_32     : default operand width of the subtractor
//   SLICE_8      : bits resolved per pipeline stage
//   stage_rec_t  : contents of one subtractor pipeline stage
//   cla4()       : 4-bit generate/propagate carry look-ahead helper
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int WIDTH_32 = 32;
    localparam int SLICE_8  = 8;

    // One pipeline stage. done holds the already-resolved low bits in their
    // final positions; pend_a/pend_b hold the unprocessed high operand bits,
    // shifted down so the next slice always works on bits [SLICE-1:0].
    typedef struct packed {
        logic                valid;
        logic [WIDTH_32-1:0] done;
        logic [WIDTH_32-1:0] pend_a;
        logic [WIDTH_32-1:0] pend_b;
        logic                carry;   // carry = ~borrow into the next slice
        logic                a_msb;
        logic                b_msb;
    } stage_rec_t;

    // 4-bit look-ahead: returns {cout, c3, c2, c1, c0} where ci is the carry
    // into bit i of the group (c0 = cin).
    function automatic logic [4:0] cla4(input logic [3:0] g,
                                        input logic [3:0] p,
                                        input logic       cin);
        logic c1;
        logic c2;
        logic c3;
        logic c4;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c4, c3, c2, c1, cin};
    endfunction

endpackage

// File: rtl/sub_slice8.sv
// -----------------------------------------------------------------------------
// sub_slice8
// Combinational 8-bit slice computing a + ~b + cin, i.e. a - b - ~cin.
// Two 4-bit look-ahead groups; the upper group takes the lower group's cout.
//   a, b  : slice operands
//   cin   : carry in (= ~borrow in)
//   sum   : slice result bits
//   cout  : carry out (= ~borrow out)
// -----------------------------------------------------------------------------
import arith_pkg::*;

module sub_slice8 (
    input  logic [SLICE_8-1:0] a,
    input  logic [SLICE_8-1:0] b,
    input  logic               cin,
    output logic [SLICE_8-1:0] sum,
    output logic               cout
);

    logic [SLICE_8-1:0] nb_s;
    logic [SLICE_8-1:0] g_s;
    logic [SLICE_8-1:0] p_s;
    logic [4:0]         lo_s;
    logic [4:0]         hi_s;

    // Generate/propagate against the inverted subtrahend, then resolve carries
    always_comb begin
        nb_s = ~b;
        g_s  = a & nb_s;
        p_s  = a ^ nb_s;
        lo_s = cla4(g_s[3:0], p_s[3:0], cin);
        hi_s = cla4(g_s[7:4], p_s[7:4], lo_s[4]);
        sum  = p_s ^ {hi_s[3:0], lo_s[3:0]};
        cout = hi_s[4];
    end

endmodule

// File: rtl/pipelined_sub32.sv
// -----------------------------------------------------------------------------
// pipelined_sub32
// Valid/ready pipelined subtractor: diff = a - b - bin, one 8-bit slice per
// stage, borrow carried between stages as a registered carry (~borrow).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout, of)
//   diff                : (a - b - bin) mod 2^WIDTH
//   bout                : unsigned borrow out (a < b + bin)
//   of                  : two's-complement overflow
// Only the default WIDTH=32 / SLICE=8 geometry is supported (stage record
// and slice cell are sized for it).
// -----------------------------------------------------------------------------
import arith_pkg::*;

module pipelined_sub32 #(
    parameter int WIDTH = WIDTH_32,
    parameter int SLICE = SLICE_8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             of
);

    localparam int STAGES = WIDTH / SLICE;

    // Stages 0..STAGES-2 are records; the final stage is the output register.
    stage_rec_t       stage_r     [0:STAGES-2];
    stage_rec_t       stage_nxt_s [0:STAGES-2];

    logic [SLICE-1:0] sa_s  [0:STAGES-1];
    logic [SLICE-1:0] sb_s  [0:STAGES-1];
    logic [SLICE-1:0] sum_s [0:STAGES-1];
    logic             cin_s [0:STAGES-1];
    logic             cout_s[0:STAGES-1];

    logic             adv_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             of_r;
    logic             out_valid_nxt_s;
    logic [WIDTH-1:0] diff_nxt_s;
    logic             bout_nxt_s;
    logic             of_nxt_s;

    // Whole pipe moves together; an empty or consumed output slot frees it
    always_comb begin
        adv_s    = ~out_valid_r | out_ready;
        in_ready = adv_s;
    end

    // Slice k always works on the low SLICE bits of the previous stage's
    // pending operands; slice 0 works straight off the ports
    always_comb begin
        sa_s[0]  = a[SLICE-1:0];
        sb_s[0]  = b[SLICE-1:0];
        cin_s[0] = ~bin;
        for (int k = 1; k < STAGES; k++) begin
            sa_s[k]  = stage_r[k-1].pend_a[SLICE-1:0];
            sb_s[k]  = stage_r[k-1].pend_b[SLICE-1:0];
            cin_s[k] = stage_r[k-1].carry;
        end
    end

    for (genvar gk = 0; gk < STAGES; gk++) begin : g_slice
        sub_slice8 u_slice (
            .a    (sa_s[gk]),
            .b    (sb_s[gk]),
            .cin  (cin_s[gk]),
            .sum  (sum_s[gk]),
            .cout (cout_s[gk])
        );
    end

    // Next contents of every intermediate stage record
    always_comb begin
        stage_nxt_s[0].valid            = in_valid;
        stage_nxt_s[0].done             = '0;
        stage_nxt_s[0].done[SLICE-1:0]  = sum_s[0];
        stage_nxt_s[0].pend_a           = a >> SLICE;
        stage_nxt_s[0].pend_b           = b >> SLICE;
        stage_nxt_s[0].carry            = cout_s[0];
        stage_nxt_s[0].a_msb            = a[WIDTH-1];
        stage_nxt_s[0].b_msb            = b[WIDTH-1];
        for (int k = 1; k < STAGES - 1; k++) begin
            stage_nxt_s[k]                       = stage_r[k-1];
            stage_nxt_s[k].done[k*SLICE +: SLICE] = sum_s[k];
            stage_nxt_s[k].pend_a                = stage_r[k-1].pend_a >> SLICE;
            stage_nxt_s[k].pend_b                = stage_r[k-1].pend_b >> SLICE;
            stage_nxt_s[k].carry                 = cout_s[k];
        end
    end

    // Final slice and flags; bubbles present all-zero data at the outputs
    always_comb begin
        out_valid_nxt_s = stage_r[STAGES-2].valid;
        diff_nxt_s      = stage_r[STAGES-2].done;
        diff_nxt_s[(STAGES-1)*SLICE +: SLICE] = sum_s[STAGES-1];
        bout_nxt_s      = ~cout_s[STAGES-1];
        of_nxt_s        = (stage_r[STAGES-2].a_msb != stage_r[STAGES-2].b_msb) &
                          (diff_nxt_s[WIDTH-1] != stage_r[STAGES-2].a_msb);
        if (!stage_r[STAGES-2].valid) begin
            diff_nxt_s = '0;
            bout_nxt_s = 1'b0;
            of_nxt_s   = 1'b0;
        end else begin
            diff_nxt_s = diff_nxt_s;
        end
    end

    // Stage and output registers: clear on reset, shift on advance, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                stage_r[k] <= '0;
            end
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            bout_r      <= 1'b0;
            of_r        <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                stage_r[k] <= stage_nxt_s[k];
            end
            out_valid_r <= out_valid_nxt_s;
            diff_r      <= diff_nxt_s;
            bout_r      <= bout_nxt_s;
            of_r        <= of_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign of        = of_r;

endmodule

// File: tb/tb_pipelined_sub32.sv
// -----------------------------------------------------------------------------
// tb_pipelined_sub32
// Self-checking bench: an arithmetic reference model feeds a queue of expected
// results; a negedge monitor checks every presented output against it.
// Directed cases pin the model and the 4-cycle latency.
// -----------------------------------------------------------------------------
module tb_pipelined_sub32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
    logic        of;

    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;
    logic        prev_rst = 1'b0;
    logic [33:0] exp_q[$];

    pipelined_sub32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .of        (of)
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, returns {of, bout, diff}
    function automatic logic [33:0] model(input logic [31:0] ma,
                                          input logic [31:0] mb,
                                          input logic        mbin);
        logic [32:0] u;
        longint      s;
        logic        o;
        u = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        s = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {o, u[32], u[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare outputs with model queue, track accepts/consumes
    always @(negedge clk) begin
        if (prev_rst && !rst) begin
            check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("post_rst_diff", {32'd0, diff}, 64'd0);
            check("post_rst_flags", {62'd0, bout, of}, 64'd0);
            check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid) | out_ready});
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    check("diff", {32'd0, diff}, {32'd0, exp_q[0][31:0]});
                    check("bout", {63'd0, bout}, {63'd0, exp_q[0][32]});
                    check("of",   {63'd0, of},   {63'd0, exp_q[0][33]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(a, b, bin));
                accepted++;
            end
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic rand_op();
        a   = $urandom;
        b   = $urandom;
        bin = 1'($urandom_range(1, 0));
        if ($urandom_range(3, 0) == 0) b = a;
    endtask

    // Single op on an empty pipe: pins the model, the latency and the outputs
    task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tbin, input logic [31:0] ed, input logic eb, input logic eo);
        int n;
        check({name, "_model"}, {30'd0, model(ta, tb, tbin)}, {30'd0, eo, eb, ed});
        tick();
        a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) break;
        end
        #1;
        check({name, "_latency"}, 64'(n), 64'd4);
        check({name, "_diff"}, {32'd0, diff}, {32'd0, ed});
        check({name, "_bout"}, {63'd0, bout}, {63'd0, eb});
        check({name, "_of"}, {63'd0, of}, {63'd0, eo});
        drain();
    endtask

    // Issue random ops until total accepted reaches target (bounded)
    task automatic issue_until(input int target);
        int guard;
        guard = 0;
        rand_op();
        in_valid = 1'b1;
        while (accepted < target && guard < 50) begin
            tick();
            guard++;
            if (accepted < target) rand_op();
        end
        if (guard >= 50) check("issue_timeout", 64'd1, 64'd0);
    endtask

    initial begin : main
        logic [31:0] held;
        int          guard;
        int          base;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        directed("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        directed("wrap",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("eq_bin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("of_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed("of_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        directed("xslice", 32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);

        // Streaming with a stall while the first result sits at the output
        out_ready = 1'b0;
        base = accepted;
        issue_until(base + 4);
        @(negedge clk);
        #1;
        held = diff;
        repeat (5) begin
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_diff", {32'd0, diff}, {32'd0, held});
            @(negedge clk);
            #1;
        end
        tick();
        out_ready = 1'b1;
        issue_until(base + 8);
        drain();
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight; in_valid held high during reset
        out_ready = 1'b1;
        base = accepted;
        issue_until(base + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (8) tick();
        directed("after_rst", 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFEF, 1'b1, 1'b0);

        // Random traffic with random valid/ready
        base  = accepted;
        guard = 0;
        while (accepted < base + 10000 && guard < 40000) begin
            tick();
            guard++;
            rand_op();
            in_valid  = ($urandom_range(9, 0) < 7);
            out_ready = ($urandom_range(9, 0) < 7);
        end
        if (guard >= 40000) check("random_timeout", 64'd1, 64'd0);
        drain();
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
